// File: rtl/postu_pkg.sv
// postu_pkg: shared types, tile geometry constants and per-mode last-index helpers.
// Used by the POSTU_SAT_EN-configurable tile sequencer.
package postu_pkg;
    typedef enum logic {MODE_DE = 1'b0, MODE_RF = 1'b1} postu_mode_e;
    typedef enum logic [1:0] {ST_IDLE, ST_ROW, ST_COL} postu_state_e;
    localparam int ROWS_RF = 4;
    localparam int ROWS_DE = 6;
    localparam int COLS_RF = 2;
    localparam int COLS_DE = 4;
    localparam int XF_MAX_IN = 6;
    localparam int XF_MAX_OUT = 4;
    function automatic logic [2:0] last_row(postu_mode_e m);
        return 3'(m == MODE_RF ? ROWS_RF - 1 : ROWS_DE - 1);
    endfunction
    function automatic logic [1:0] last_col(postu_mode_e m);
        return 2'(m == MODE_RF ? COLS_RF - 1 : COLS_DE - 1);
    endfunction
endpackage

// File: rtl/postu_tile_sequencer_if.sv
// postu_tile_sequencer_if: row input and column output handshakes of the tile sequencer.
interface postu_tile_sequencer_if #(parameter int A_bits = 12) ();
    logic                  in_valid;
    logic                  in_ready;
    logic                  in_mode;
    logic [6*A_bits-1:0]   in_row;
    logic                  out_valid;
    logic                  out_ready;
    logic [4*A_bits-1:0]   out_col;
    logic                  out_last;
    modport master (output in_valid, in_mode, in_row, out_ready,
                    input  in_ready, out_valid, out_col, out_last);
    modport slave  (input  in_valid, in_mode, in_row, out_ready,
                    output in_ready, out_valid, out_col, out_last);
endinterface

// File: rtl/postu_row_xform.sv
// postu_row_xform: combinational rf/de output transform of one 6-vector into a 4-vector.
// POSTU_SAT_EN selects clamping (with clamp flag) instead of two's-complement wrap.
module postu_row_xform import postu_pkg::*; #(
    parameter int A_bits = 12
) (
    input  postu_mode_e              mode_i,
    input  logic signed [A_bits-1:0] t_i [XF_MAX_IN],
    output logic signed [A_bits-1:0] o_o [XF_MAX_OUT],
    output logic                     clamp_o
);
    localparam int W = A_bits + 2;
    logic signed [W-1:0] t [XF_MAX_IN];
    logic signed [W-1:0] s [XF_MAX_OUT];
`ifdef POSTU_SAT_EN
    localparam logic signed [W-1:0] S_MAX = W'((1 << (A_bits - 1)) - 1);
    localparam logic signed [W-1:0] S_MIN = ~S_MAX;
`endif
    always_comb begin
        for (int i = 0; i < XF_MAX_IN; i++) t[i] = {{2{t_i[i][A_bits-1]}}, t_i[i]};
        s[0] = mode_i == MODE_RF ? t[0] + t[1] + t[2] : t[0] + t[1];
        s[1] = mode_i == MODE_RF ? t[1] + t[3] - t[2] : t[3] + t[4];
        s[2] = mode_i == MODE_RF ? '0 : t[1] + t[2];
        s[3] = mode_i == MODE_RF ? '0 : t[4] + t[5];
        clamp_o = 1'b0;
        for (int i = 0; i < XF_MAX_OUT; i++) begin
`ifdef POSTU_SAT_EN
            o_o[i] = s[i] > S_MAX ? S_MAX[A_bits-1:0] : s[i] < S_MIN ? S_MIN[A_bits-1:0] : s[i][A_bits-1:0];
            clamp_o = clamp_o | (s[i] > S_MAX) | (s[i] < S_MIN);
`else
            o_o[i] = s[i][A_bits-1:0];
`endif
        end
    end
endmodule

// File: rtl/postu_tile_sequencer.sv
// postu_tile_sequencer: row pass into a transpose buffer, then column pass out, sharing one xform.
// POSTU_SAT_EN enables clamping and the sticky sat_seen_o flag.
module postu_tile_sequencer import postu_pkg::*; #(
    parameter int A_bits = 12
) (
    input  logic                    clk,
    input  logic                    rst,
    postu_tile_sequencer_if.slave   bus,
    output logic                    busy_o,
    output logic                    sat_seen_o
);
    postu_state_e             state_q;
    postu_mode_e              mode_q, xf_mode;
    logic [2:0]               rcnt_q;
    logic [1:0]               ccnt_q;
    logic                     in_ready_q, out_valid_q, out_last_q, busy_q, sat_q;
    logic signed [A_bits-1:0] buf_q [XF_MAX_IN][XF_MAX_OUT];
    logic signed [A_bits-1:0] xf_t [XF_MAX_IN];
    logic signed [A_bits-1:0] xf_o [XF_MAX_OUT];
    logic                     xf_clamp, in_fire, out_fire;
    assign in_fire  = bus.in_valid && in_ready_q;
    assign out_fire = out_valid_q && bus.out_ready;
    assign xf_mode  = state_q == ST_IDLE ? postu_mode_e'(bus.in_mode) : mode_q;
    // Column pass reads buffer column ccnt; otherwise the incoming row feeds the xform.
    always_comb begin
        for (int i = 0; i < XF_MAX_IN; i++)
            xf_t[i] = state_q == ST_COL ? buf_q[i][ccnt_q] : bus.in_row[i*A_bits +: A_bits];
        for (int l = 0; l < XF_MAX_OUT; l++)
            bus.out_col[l*A_bits +: A_bits] = out_valid_q ? xf_o[l] : '0;
    end
    postu_row_xform #(.A_bits(A_bits)) u_xf (
        .mode_i (xf_mode),
        .t_i    (xf_t),
        .o_o    (xf_o),
        .clamp_o(xf_clamp)
    );
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            mode_q      <= MODE_DE;
            rcnt_q      <= '0;
            ccnt_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            sat_q       <= 1'b0;
            for (int r = 0; r < XF_MAX_IN; r++)
                for (int l = 0; l < XF_MAX_OUT; l++) buf_q[r][l] <= '0;
        end else begin
            if ((in_fire || out_fire) && xf_clamp) sat_q <= 1'b1;
            case (state_q)
                ST_IDLE: if (in_fire) begin
                    mode_q   <= xf_mode;
                    buf_q[0] <= xf_o;
                    rcnt_q   <= 3'd1;
                    busy_q   <= 1'b1;
                    state_q  <= ST_ROW;
                end
                ST_ROW: if (in_fire) begin
                    buf_q[rcnt_q] <= xf_o;
                    rcnt_q        <= rcnt_q + 3'd1;
                    if (rcnt_q == last_row(mode_q)) begin
                        state_q     <= ST_COL;
                        ccnt_q      <= '0;
                        in_ready_q  <= 1'b0;
                        out_valid_q <= 1'b1;
                        out_last_q  <= 1'b0;
                    end
                end
                ST_COL: if (out_fire) begin
                    if (ccnt_q == last_col(mode_q)) begin
                        state_q     <= ST_IDLE;
                        in_ready_q  <= 1'b1;
                        out_valid_q <= 1'b0;
                        out_last_q  <= 1'b0;
                        busy_q      <= 1'b0;
                    end else begin
                        ccnt_q     <= ccnt_q + 2'd1;
                        out_last_q <= (ccnt_q + 2'd1) == last_col(mode_q);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end
    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_last  = out_last_q;
    assign busy_o        = busy_q;
    assign sat_seen_o    = sat_q;
endmodule
